// File: rtl/cdce_spi_arbiter.sv
// cdce_spi_arbiter: shares the CDCE62005 SPI engine between the DSP
// register bridge (req0) and the monitor/lock poller (req1), round-robin.
module cdce_spi_arbiter #(
    parameter int unsigned START_HOLD   = 3,
    parameter logic [19:0] BUSY_TIMEOUT = 20'd64,
    parameter logic [19:0] DONE_TIMEOUT = 20'd200000
) (
    input  logic        FPGA_48MHz,
    input  logic        FPGA_rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_wdata,
    output logic        req0_ack,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic [31:0] req1_wdata,
    output logic        req1_ack,
    output logic        req1_done,
    output logic        req1_err,
    output logic [31:0] rdata,
    output logic        eng_start,
    output logic [31:0] eng_wdata,
    input  logic        eng_busy,
    input  logic [31:0] eng_rdata,
    output logic        arb_busy,
    output logic        grant_id
);

    localparam logic [7:0] HOLD = 8'(START_HOLD);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t      state;
    logic [1:0]  idle_cnt;
    logic [19:0] timer;
    logic [19:0] timer_nxt;
    logic [7:0]  hold_cnt;
    logic        any_valid;
    logic        pick;
    logic        fin;
    logic        fin_err;

    assign arb_busy = (state != IDLE);

    // Requester selection and frame-completion decode
    always_comb begin
        any_valid = req0_valid | req1_valid;
        pick      = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        timer_nxt = (&timer) ? timer : timer + 20'd1;
        if (req0_valid && req1_valid) begin
            pick = ~grant_id;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
        if (state == WAIT_BUSY && !eng_busy && timer >= BUSY_TIMEOUT) begin
            fin     = 1'b1;
            fin_err = 1'b1;
        end
        if (state == WAIT_DONE) begin
            if (!eng_busy) begin
                fin = 1'b1;
            end else if (timer >= DONE_TIMEOUT) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered handshake and engine outputs
    always_ff @(posedge FPGA_48MHz or negedge FPGA_rst) begin
        if (!FPGA_rst) begin
            state     <= IDLE;
            idle_cnt  <= 2'd0;
            timer     <= 20'd0;
            hold_cnt  <= 8'd0;
            eng_start <= 1'b0;
            eng_wdata <= 32'd0;
            rdata     <= 32'd0;
            grant_id  <= 1'b1;
            req0_ack  <= 1'b0;
            req0_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_ack  <= 1'b0;
            req1_done <= 1'b0;
            req1_err  <= 1'b0;
        end else begin
            req0_ack  <= 1'b0;
            req0_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_ack  <= 1'b0;
            req1_done <= 1'b0;
            req1_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (eng_busy) begin
                        idle_cnt <= 2'd0;
                    end else if (idle_cnt != 2'd2) begin
                        idle_cnt <= idle_cnt + 2'd1;
                    end
                    if (idle_cnt == 2'd2 && any_valid) begin
                        idle_cnt  <= 2'd0;
                        hold_cnt  <= 8'd0;
                        grant_id  <= pick;
                        eng_wdata <= pick ? req1_wdata : req0_wdata;
                        req0_ack  <= ~pick;
                        req1_ack  <= pick;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hold_cnt == HOLD) begin
                        eng_start <= 1'b0;
                        timer     <= 20'd0;
                        state     <= WAIT_BUSY;
                    end else begin
                        eng_start <= 1'b1;
                        hold_cnt  <= hold_cnt + 8'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (eng_busy) begin
                        timer <= 20'd0;
                        state <= WAIT_DONE;
                    end else if (!fin) begin
                        timer <= timer_nxt;
                    end
                end
                WAIT_DONE: begin
                    if (!fin) begin
                        timer <= timer_nxt;
                    end
                end
                COMPLETE: begin
                    idle_cnt <= 2'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (fin) begin
                rdata     <= eng_rdata;
                req0_done <= ~grant_id;
                req0_err  <= ~grant_id & fin_err;
                req1_done <= grant_id;
                req1_err  <= grant_id & fin_err;
                state     <= COMPLETE;
            end
        end
    end

endmodule
